perm_layer_stage: RTL and testbench
===================================

# perm_layer_stage

Bit-permutation stage of the cipher round datapath, sitting directly downstream of the 4-bit substitution layer (16 parallel 4-bit S-boxes over a 64-bit state). Accepts one 64-bit substituted state per valid/ready transfer, applies the fixed 64-bit permutation or its inverse, and presents the result through a 2-entry elastic buffer to the round-key / round-control stage. Round tags travel with the data unchanged so the round controller can match results to rounds.

## Interface
- WIDTH, 64: state width in bits. Fixed at 64; other values are unsupported.
- TAGW, 5: width of the round tag carried alongside each state.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
- in_valid  input  1  upstream has a state on in_data.
- in_ready  output  1  stage can accept a transfer this cycle.
- in_data  input  WIDTH  substituted state from the S-box layer.
- in_tag  input  TAGW  round number of in_data.
- in_inv  input  1  0 = forward permutation (encrypt), 1 = inverse (decrypt); per transfer.
- out_valid  output  1  out_data/out_tag hold a result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  permuted state.
- out_tag  output  TAGW  tag of out_data, copied from in_tag.
- occupancy  output  2  number of results held, 0..2.

## Operation
- Forward map: input bit i moves to output bit P(i) = (16*i) mod 63 for i = 0..62; bit 63 stays at 63.
- Inverse map: input bit j moves to output bit (4*j) mod 63 for j = 0..62; bit 63 stays at 63. Inverse(forward(x)) = x for every x.
- Permutation is pure wiring, computed on in_data before storage; no arithmetic. in_inv selects the map per transfer and is not stored.
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- Buffer: 2-entry FIFO of {permuted data, tag}; out_data/out_tag always show the oldest entry; order is preserved.
- in_ready = (occupancy != 2) and rst_n high; depends only on registered state, never combinationally on out_ready.
- out_valid = (occupancy != 0).
- Occupancy transitions: push only +1; pop only -1; push and pop in the same cycle leaves occupancy unchanged, with the popped entry replaced by the next oldest and the new entry appended.
- Pop at occupancy 0 and push at occupancy 2 cannot occur (handshakes prevent them); no error state.
- out_data/out_tag hold their value while out_valid && !out_ready (no change under backpressure).
- Values on in_data/in_tag/in_inv are ignored when no input transfer occurs.

## Timing
- Reset (rst_n low at a rising edge): occupancy = 0, out_valid = 0, out_data = 0, out_tag = 0, both entries cleared; in_ready = 0 while rst_n is low and 1 on the first cycle after release.
- Reset mid-operation discards all held entries; nothing in flight is emitted afterward.
- Latency: a transfer accepted at edge N appears on out_data with out_valid high after edge N (one cycle) when the buffer was empty.
- Throughput: one transfer per cycle sustained when out_ready is held high.
- Backpressure: with out_ready low, exactly two transfers are accepted, then in_ready drops in the cycle after the second accept.
- in_ready returns high in the cycle after the first pop from a full buffer.

## Test plan
- Forward single bits: in_inv=0, in_data 64'h1 -> 64'h1; 64'h2 -> 64'h0000_0000_0001_0000; 64'h10 -> 64'h2; 64'h8000_0000_0000_0000 -> unchanged; out_tag equals in_tag, latency 1 cycle.
- Inverse and round trip: in_inv=1, 64'h0000_0000_0001_0000 -> 64'h2; random 64-bit x forward, then feed the result back inverse -> x; 64'hFFFF_FFFF_FFFF_FFFF -> all ones in both modes.
- Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> tags 1,2 accepted, in_ready=0, occupancy=2, out_data stable; release out_ready -> outputs tags 1,2,3 in order, no loss or duplication.
- Streaming: in_valid and out_ready high for 32 cycles, tags 0..31, alternating in_inv -> one output per cycle, occupancy stays 1, each output matches its selected map.
- Simultaneous push/pop at occupancy 1 and 2-to-1 transitions with random out_ready toggling -> scoreboard matches golden permutation and order for 1000 transfers.
- Reset mid-stream: occupancy 2, assert rst_n low for 1 cycle -> out_valid=0, out_data=0, out_tag=0, occupancy=0 next cycle, in_ready=1 after release; pre-reset entries never emerge.

Source files
------------

// File: rtl/perm_layer_stage_if.sv
// rtl/perm_layer_stage_if.sv - handshake bundle between S-box layer, permutation stage and round-key stage
interface perm_layer_stage_if #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [TAGW-1:0]  in_tag;
  logic             in_inv;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAGW-1:0]  out_tag;
  logic [1:0]       occupancy;

  // Upstream/downstream side that drives requests and consumes results
  modport master (
    output in_valid, in_data, in_tag, in_inv, out_ready,
    input  in_ready, out_valid, out_data, out_tag, occupancy
  );

  // The permutation stage itself
  modport slave (
    input  in_valid, in_data, in_tag, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_tag, occupancy
  );
endinterface

// File: rtl/perm_layer_stage.sv
// rtl/perm_layer_stage.sv - 64-bit bit permutation (forward/inverse) with 2-entry elastic output buffer
module perm_layer_stage #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  perm_layer_stage_if.slave  s
);

  localparam int EW = WIDTH + TAGW;

  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] inv;
  logic [EW-1:0]    new_entry;
  logic [EW-1:0]    e0;
  logic [EW-1:0]    e1;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  // Fixed wiring: forward sends bit i to 16*i mod 63, inverse sends bit j to 4*j mod 63; bit 63 is a fixed point
  for (genvar g = 0; g < 63; g++) begin : g_map
    assign fwd[(16 * g) % 63] = s.in_data[g];
    assign inv[(4 * g) % 63]  = s.in_data[g];
  end
  assign fwd[63] = s.in_data[63];
  assign inv[63] = s.in_data[63];

  assign new_entry = {(s.in_inv ? inv : fwd), s.in_tag};

  // Ready comes only from registered occupancy so it never chains through out_ready
  assign s.in_ready  = rst_n && (cnt != 2'd2);
  assign s.out_valid = (cnt != 2'd0);
  assign s.occupancy = cnt;
  assign s.out_data  = e0[EW-1:TAGW];
  assign s.out_tag   = e0[TAGW-1:0];

  assign push = s.in_valid && s.in_ready;
  assign pop  = s.out_valid && s.out_ready;

  // Two-slot FIFO: e0 is always the oldest entry and drives the outputs directly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= new_entry;
          else             e1 <= new_entry;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          e1  <= '0;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= new_entry;
          end else begin
            e0 <= e1;
            e1 <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_layer_stage.sv
// tb/tb_perm_layer_stage.sv - self-checking bench for perm_layer_stage
module tb_perm_layer_stage;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  perm_layer_stage_if #(.WIDTH(64), .TAGW(5)) ifc ();

  perm_layer_stage #(.WIDTH(64), .TAGW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
  } ent_t;

  ent_t q[$];

  // Gather form of the maps: output bit k of the forward map comes from input bit 4k mod 63
  function automatic logic [63:0] golden(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y[63] = x[63];
    for (int k = 0; k < 63; k++)
      y[k] = inv ? x[(16 * k) % 63] : x[(4 * k) % 63];
    return y;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference buffer: updated from the inputs at each rising edge
  always @(posedge clk) begin
    bit   do_push, do_pop;
    ent_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      do_pop  = ifc.out_ready && (q.size() > 0);
      do_push = ifc.in_valid && (q.size() < 2);
      e.d = golden(ifc.in_data, ifc.in_inv);
      e.t = ifc.in_tag;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Per-cycle comparison of DUT outputs against the reference buffer
  always begin
    @(posedge clk);
    #4;
    chk("occupancy", 64'(ifc.occupancy), 64'(q.size()));
    chk("out_valid", 64'(ifc.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(ifc.in_ready), 64'(rst_n && (q.size() < 2)));
    if (q.size() > 0) begin
      chk("out_data", ifc.out_data, q[0].d);
      chk("out_tag", 64'(ifc.out_tag), 64'(q[0].t));
    end
  end

  logic [63:0] vin  [7] = '{64'h1, 64'h2, 64'h10, 64'h8000_0000_0000_0000,
                            64'h0000_0000_0001_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'hFFFF_FFFF_FFFF_FFFF};
  logic        vinv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] vexp [7] = '{64'h1, 64'h0000_0000_0001_0000, 64'h2, 64'h8000_0000_0000_0000,
                            64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  initial begin
    logic [63:0] x, y, saved;
    int          accepted, popped, cycles;

    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_tag    = '0;
    ifc.in_inv    = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset out_valid", 64'(ifc.out_valid), 64'd0);
    chk("reset out_data", ifc.out_data, 64'd0);
    chk("reset out_tag", 64'(ifc.out_tag), 64'd0);
    chk("reset occupancy", 64'(ifc.occupancy), 64'd0);
    chk("reset in_ready", 64'(ifc.in_ready), 64'd0);

    chk("model fwd 2", golden(64'h2, 1'b0), 64'h0000_0000_0001_0000);
    chk("model fwd 10", golden(64'h10, 1'b0), 64'h2);
    chk("model inv 10000", golden(64'h0000_0000_0001_0000, 1'b1), 64'h2);

    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after release", 64'(ifc.in_ready), 64'd1);

    // Directed single vectors, one-cycle latency
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = vin[i];
      ifc.in_inv   = vinv[i];
      ifc.in_tag   = 5'(i + 3);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      chk("vec out_valid", 64'(ifc.out_valid), 64'd1);
      chk("vec out_data", ifc.out_data, vexp[i]);
      chk("vec out_tag", 64'(ifc.out_tag), 64'(i + 3));
    end
    @(negedge clk);

    // Round trip: forward then inverse gives back the original
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom};
      ifc.in_valid = 1'b1;
      ifc.in_data  = x;
      ifc.in_inv   = 1'b0;
      ifc.in_tag   = 5'(20 + i);
      @(negedge clk);
      y = ifc.out_data;
      ifc.in_data = y;
      ifc.in_inv  = 1'b1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      chk("round trip", ifc.out_data, x);
    end
    repeat (2) @(negedge clk);

    // Backpressure: only two accepted, head stays still
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_inv    = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      ifc.in_tag  = 5'(t);
      ifc.in_data = 64'h0123_4567_89AB_CDEF ^ 64'(t);
      @(negedge clk);
    end
    chk("bp in_ready", 64'(ifc.in_ready), 64'd0);
    chk("bp occupancy", 64'(ifc.occupancy), 64'd2);
    chk("bp head tag", 64'(ifc.out_tag), 64'd1);
    saved = ifc.out_data;
    repeat (3) begin
      @(negedge clk);
      chk("bp data stable", ifc.out_data, saved);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("bp ready back", 64'(ifc.in_ready), 64'd1);
    chk("bp second tag", 64'(ifc.out_tag), 64'd2);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("bp third tag", 64'(ifc.out_tag), 64'd3);
    @(negedge clk);
    chk("bp drained", 64'(ifc.out_valid), 64'd0);

    // Streaming with alternating direction
    for (int k = 0; k < 32; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = {$urandom, $urandom};
      ifc.in_tag   = 5'(k);
      ifc.in_inv   = k[0];
      if (k > 0) begin
        chk("stream occupancy", 64'(ifc.occupancy), 64'd1);
        chk("stream tag", 64'(ifc.out_tag), 64'(k - 1));
      end
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    chk("stream last tag", 64'(ifc.out_tag), 64'd31);
    @(negedge clk);

    // Random valid/ready toggling over 1000 accepted transfers
    accepted = 0;
    popped   = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 10000) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = $urandom_range(0, 1);
      ifc.in_data   = {$urandom, $urandom};
      ifc.in_tag    = 5'(accepted);
      ifc.in_inv    = $urandom_range(0, 1);
      #1;
      if (ifc.in_valid && ifc.in_ready) accepted++;
      if (ifc.out_valid && ifc.out_ready) popped++;
      @(negedge clk);
      cycles++;
    end
    chk("random accepted", 64'(accepted), 64'd1000);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (4) begin
      if (ifc.out_valid) popped++;
      @(negedge clk);
    end
    chk("random popped", 64'(popped), 64'd1000);

    // Reset with a full buffer
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    for (int t = 0; t < 2; t++) begin
      ifc.in_tag  = 5'(9 + t);
      ifc.in_data = 64'hDEAD_BEEF_0000_0000 | 64'(t);
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    chk("pre-reset occupancy", 64'(ifc.occupancy), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset out_valid", 64'(ifc.out_valid), 64'd0);
    chk("mid reset out_data", ifc.out_data, 64'd0);
    chk("mid reset out_tag", 64'(ifc.out_tag), 64'd0);
    chk("mid reset occupancy", 64'(ifc.occupancy), 64'd0);
    chk("mid reset in_ready", 64'(ifc.in_ready), 64'd0);
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    #1;
    chk("post reset in_ready", 64'(ifc.in_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("no stale output", 64'(ifc.out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
